// File: rtl/vend_pkg.sv
// Shared constants for the vending front-end: coin bit positions, coin values,
// default pricing/limits and the controller state encoding.
package vend_pkg;

  localparam int COIN_5  = 0;
  localparam int COIN_10 = 1;
  localparam int COIN_20 = 2;
  localparam int COIN_50 = 3;

  localparam logic [7:0] VAL_5  = 8'd5;
  localparam logic [7:0] VAL_10 = 8'd10;
  localparam logic [7:0] VAL_20 = 8'd20;
  localparam logic [7:0] VAL_50 = 8'd50;

  localparam int PRICE_DEF       = 25;
  localparam int MAX_CREDIT_DEF  = 200;
  localparam int CHG_TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    ARM      = 2'd2,
    WAIT_CHG = 2'd3
  } state_t;

endpackage

// File: rtl/coin_decode.sv
// Combinational coin decoder: a single set bit maps to its value; anything else
// (no bit or several bits) is reported as not valid with value 0.
module coin_decode
  import vend_pkg::*;
(
  input  logic [3:0] coin,
  output logic [7:0] value,
  output logic       valid
);

  localparam logic [3:0] ONE = 4'b0001;

  always_comb begin
    value = '0;
    valid = 1'b0;
    case (coin)
      ONE << COIN_5:  begin value = VAL_5;  valid = 1'b1; end
      ONE << COIN_10: begin value = VAL_10; valid = 1'b1; end
      ONE << COIN_20: begin value = VAL_20; valid = 1'b1; end
      ONE << COIN_50: begin value = VAL_50; valid = 1'b1; end
      default:        begin value = '0;     valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending front-end: accumulates coin credit, resolves buy/cancel, hands the
// amount to the change dispenser and waits (bounded) for it to finish.
// Dispenser handshake: en is a one-cycle start strobe with money/move25 stable;
// the dispenser raises chg_flag while paying and drops it when done.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE       = PRICE_DEF,
  parameter int MAX_CREDIT  = MAX_CREDIT_DEF,
  parameter int CHG_TIMEOUT = CHG_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] coin,
  input  logic       buy,
  input  logic       cancel,
  input  logic       chg_flag,
  output logic [7:0] money,
  output logic       en,
  output logic       move25,
  output logic [7:0] credit,
  output logic       vend,
  output logic       coin_reject,
  output logic       busy,
  output logic       timeout_err,
  output logic [1:0] state
);

  localparam int CW = $clog2(CHG_TIMEOUT + 1);

  state_t          state_q;
  logic [CW-1:0]   cnt;
  logic [7:0]      coin_value;
  logic            coin_valid;
  logic [8:0]      sum;
  logic            coin_seen;
  logic            buy_ok;
  logic            cancel_ok;
  logic            take;
  logic            coin_accept;

  coin_decode u_coin_decode (
    .coin  (coin),
    .value (coin_value),
    .valid (coin_valid)
  );

  // 9-bit sum so the ceiling check can never be fooled by 8-bit wrap.
  assign sum         = {1'b0, credit} + {1'b0, coin_value};
  assign coin_seen   = |coin;
  assign buy_ok      = (state_q == IDLE) && buy && (credit >= 8'(PRICE));
  assign cancel_ok   = (state_q == IDLE) && cancel && (credit != 8'd0) && !buy_ok;
  assign take        = buy_ok || cancel_ok;
  assign coin_accept = (state_q == IDLE) && !take && coin_valid && (sum <= 9'(MAX_CREDIT));
  assign state       = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt         <= '0;
      credit      <= '0;
      money       <= '0;
      en          <= 1'b0;
      move25      <= 1'b0;
      vend        <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      en          <= 1'b0;
      vend        <= 1'b0;
      timeout_err <= 1'b0;
      coin_reject <= coin_seen && !coin_accept;
      if (coin_accept) credit <= sum[7:0];

      case (state_q)
        IDLE: begin
          if (take) begin
            money   <= credit;
            move25  <= buy_ok;
            vend    <= buy_ok;
            credit  <= '0;
            busy    <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          en      <= 1'b1;
          state_q <= ARM;
        end
        ARM: begin
          cnt     <= '0;
          state_q <= WAIT_CHG;
        end
        WAIT_CHG: begin
          if (!chg_flag) begin
            money   <= '0;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else if (cnt == CW'(CHG_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            money       <= '0;
            busy        <= 1'b0;
            state_q     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed scenarios plus random coin stream, a simple
// change-dispenser model and an en-transaction scoreboard.
module tb_vend_ctrl;
  import vend_pkg::*;

  localparam int W = 9;

  logic       clk;
  logic       rst;
  logic [3:0] coin;
  logic       buy;
  logic       cancel;
  logic       chg_flag;
  logic [7:0] money;
  logic       en;
  logic       move25;
  logic [7:0] credit;
  logic       vend;
  logic       coin_reject;
  logic       busy;
  logic       timeout_err;
  logic [1:0] state;

  logic [W-1:0] exp_q[$];
  logic [7:0]   ret_log[$];
  logic         disp_stuck;
  int           n_checks = 0;
  int           n_fail   = 0;

  vend_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .coin        (coin),
    .buy         (buy),
    .cancel      (cancel),
    .chg_flag    (chg_flag),
    .money       (money),
    .en          (en),
    .move25      (move25),
    .credit      (credit),
    .vend        (vend),
    .coin_reject (coin_reject),
    .busy        (busy),
    .timeout_err (timeout_err),
    .state       (state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] coin_val(input logic [3:0] c);
    case (c)
      4'b0001: return 8'd5;
      4'b0010: return 8'd10;
      4'b0100: return 8'd20;
      4'b1000: return 8'd50;
      default: return 8'd0;
    endcase
  endfunction

  // scoreboard: every en must match the next expected {move25, money}
  always @(negedge clk) begin
    if (en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_en", en, 0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("en_money", money, e[7:0]);
        check("en_move25", move25, e[8]);
      end
    end
  end

  // change-dispenser model: greedy payout, one coin per cycle while chg_flag=1
  initial begin
    logic [7:0] chg;
    logic [7:0] c;
    chg_flag = 1'b0;
    forever begin
      @(negedge clk);
      if (en) begin
        chg = move25 ? money - 8'(PRICE_DEF) : money;
        chg_flag = 1'b1;
        if (disp_stuck) begin
          while (disp_stuck) @(negedge clk);
        end else begin
          while (chg != 8'd0) begin
            if (chg >= 8'd50)      c = 8'd50;
            else if (chg >= 8'd20) c = 8'd20;
            else if (chg >= 8'd10) c = 8'd10;
            else                   c = 8'd5;
            ret_log.push_back(c);
            chg = chg - c;
            @(negedge clk);
          end
        end
        chg_flag = 1'b0;
      end
    end
  end

  // driver tasks: all start and end on a negedge
  task automatic drive_coin(input logic [3:0] c, input logic exp_rej, input logic [7:0] exp_credit);
    coin = c;
    @(negedge clk);
    coin = 4'b0;
    check("coin_reject", coin_reject, exp_rej);
    check("credit", credit, exp_credit);
  endtask

  task automatic press(input logic b, input logic c, input logic [3:0] cn);
    buy = b;
    cancel = c;
    coin = cn;
    @(negedge clk);
    buy = 1'b0;
    cancel = 1'b0;
    coin = 4'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (state != IDLE && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", state, IDLE);
  endtask

  initial begin
    logic [3:0] ctab[8];
    int         model;
    int         k;
    ctab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0000, 4'b1100, 4'b1000};
    rst = 1'b1; coin = 4'b0; buy = 1'b0; cancel = 1'b0; disp_stuck = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", state, IDLE);
    check("rst_credit", credit, 0);
    check("rst_money", money, 0);
    check("rst_en", en, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // 1: 10, 10, 5, buy
    drive_coin(4'b0010, 0, 8'd10);
    drive_coin(4'b0010, 0, 8'd20);
    drive_coin(4'b0001, 0, 8'd25);
    exp_q.push_back({1'b1, 8'd25});
    press(1, 0, 4'b0);
    check("t1_vend", vend, 1);
    check("t1_money", money, 25);
    check("t1_move25", move25, 1);
    check("t1_en_early", en, 0);
    check("t1_credit", credit, 0);
    check("t1_busy", busy, 1);
    check("t1_state", state, START);
    @(negedge clk);
    check("t1_en", en, 1);
    check("t1_vend_pulse", vend, 0);
    @(negedge clk);
    check("t1_en_pulse", en, 0);
    wait_idle(100);
    check("t1_credit_end", credit, 0);
    check("t1_money_end", money, 0);

    // 2: 50, buy+cancel+coin together: buy wins, coin returned, change 20 then 5
    drive_coin(4'b1000, 0, 8'd50);
    ret_log.delete();
    exp_q.push_back({1'b1, 8'd50});
    press(1, 1, 4'b0001);
    check("t2_vend", vend, 1);
    check("t2_coin_reject", coin_reject, 1);
    check("t2_move25", move25, 1);
    check("t2_credit", credit, 0);
    wait_idle(100);
    check("t2_busy", busy, 0);
    check("t2_ret_count", ret_log.size(), 2);
    if (ret_log.size() == 2) begin
      check("t2_ret0", ret_log[0], 20);
      check("t2_ret1", ret_log[1], 5);
    end

    // 3: 20, buy denied, cancel refunds; then 10 with buy+cancel -> cancel
    drive_coin(4'b0100, 0, 8'd20);
    press(1, 0, 4'b0);
    check("t3_no_vend", vend, 0);
    check("t3_state", state, IDLE);
    check("t3_credit", credit, 20);
    exp_q.push_back({1'b0, 8'd20});
    press(0, 1, 4'b0);
    check("t3_vend", vend, 0);
    check("t3_move25", move25, 0);
    check("t3_money", money, 20);
    wait_idle(100);
    drive_coin(4'b0010, 0, 8'd10);
    exp_q.push_back({1'b0, 8'd10});
    press(1, 1, 4'b0);
    check("t3b_vend", vend, 0);
    check("t3b_state", state, START);
    wait_idle(100);

    // 4: multi-bit coin, fill to 200, overflow coin
    drive_coin(4'b0011, 1, 8'd0);
    for (int i = 1; i <= 4; i++) drive_coin(4'b1000, 0, 8'(50 * i));
    drive_coin(4'b0001, 1, 8'd200);
    exp_q.push_back({1'b0, 8'd200});
    press(0, 1, 4'b0);
    wait_idle(100);

    // random coin stream against a credit model
    model = 0;
    for (int i = 0; i < 24; i++) begin
      logic [3:0] c;
      logic       rej;
      c = ctab[$urandom_range(0, 7)];
      rej = 1'b0;
      if (c != 4'b0) begin
        if (coin_val(c) != 8'd0 && model + int'(coin_val(c)) <= MAX_CREDIT_DEF)
          model = model + int'(coin_val(c));
        else
          rej = 1'b1;
      end
      drive_coin(c, rej, 8'(model));
    end
    if (model > 0) begin
      exp_q.push_back({1'b0, 8'(model)});
      press(0, 1, 4'b0);
      wait_idle(100);
    end

    // 5: coin during WAIT_CHG rejected; stuck dispenser -> timeout after 64 cycles
    disp_stuck = 1'b1;
    drive_coin(4'b0100, 0, 8'd20);
    drive_coin(4'b0001, 0, 8'd25);
    exp_q.push_back({1'b1, 8'd25});
    press(1, 0, 4'b0);
    @(negedge clk);
    @(negedge clk);
    check("t5_state", state, WAIT_CHG);
    k = 0;
    coin = 4'b0010;
    @(negedge clk);
    coin = 4'b0;
    k++;
    check("t5_coin_reject", coin_reject, 1);
    check("t5_credit", credit, 0);
    while (!timeout_err && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t5_timeout_cycles", k, 64);
    check("t5_timeout_err", timeout_err, 1);
    check("t5_state_idle", state, IDLE);
    check("t5_busy", busy, 0);
    @(negedge clk);
    check("t5_timeout_pulse", timeout_err, 0);
    disp_stuck = 1'b0;
    repeat (2) @(negedge clk);

    // 6: reset in WAIT_CHG with money pending
    disp_stuck = 1'b1;
    drive_coin(4'b1000, 0, 8'd50);
    exp_q.push_back({1'b1, 8'd50});
    press(1, 0, 4'b0);
    @(negedge clk);
    @(negedge clk);
    check("t6_state", state, WAIT_CHG);
    check("t6_money_pending", money, 50);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_state_rst", state, IDLE);
    check("t6_credit", credit, 0);
    check("t6_money", money, 0);
    check("t6_en", en, 0);
    check("t6_move25", move25, 0);
    check("t6_vend", vend, 0);
    check("t6_coin_reject", coin_reject, 0);
    check("t6_timeout_err", timeout_err, 0);
    check("t6_busy", busy, 0);
    disp_stuck = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_state_end", state, IDLE);

    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
